rr_prio_arbiter8: RTL and testbench
===================================

Name: rr_prio_arbiter8

Overview:
- Sequential round-robin arbiter that shares one resource among 8 requesters.
- Each cycle it picks one winner with a rotating-priority version of the team's 8-to-3 priority encoder. It then holds the grant until the owner releases or a hold timeout expires.
- Sits in front of any single-port shared unit (bus, display, ALU). Downstream logic uses grant_id directly as a 3-bit select.

Parameters:
- MAX_HOLD, 15, maximum consecutive cycles one owner may hold the grant. 0 disables the timeout.
- CNT_W, 4, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request vector; bit i is requester i, level-sensitive.
- grant  out  8  one-hot grant, registered.
- grant_id  out  3  binary index of the current owner, registered. Valid only when grant_valid=1.
- grant_valid  out  1  high while some grant bit is high.
- timeout  out  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
- last_id  out  3  index of the most recent owner; this is the rotation pointer.

Behaviour:
- All state changes on the rising edge of clk. rst is sampled at the edge and has priority over everything.
- Reset values: grant=8'h00, grant_id=0, grant_valid=0, timeout=0, last_id=7 (so requester 0 has highest priority after reset), hold counter=0, state=IDLE.
- Reset asserted mid-grant: all outputs return to reset values at that edge. No timeout pulse is generated.
- Two states: IDLE and BUSY.
- Arbitration, evaluated only in IDLE:
  - Search order is last_id+1, last_id+2, ..., last_id+8, all mod 8. Wrap-around is required; e.g. last_id=6 gives order 7,0,1,...,6.
  - The first index with req=1 wins.
  - req=0 gives no grant and the state stays IDLE.
- IDLE -> BUSY, latency 1 cycle:
  - If req is non-zero at edge N, then after edge N: grant=one-hot(winner), grant_id=winner, grant_valid=1, hold counter=1.
- BUSY, owner keeps req high:
  - The grant is held and the hold counter increments each cycle.
  - Other requests are ignored while BUSY (no preemption).
  - Changes on non-owner req bits have no effect.
- BUSY -> IDLE on release:
  - Release means req[grant_id]=0 sampled at an edge.
  - After that edge: grant=0, grant_valid=0, last_id=old owner, timeout=0.
  - Exactly one idle cycle always separates two grants, even back-to-back. Earliest new grant is 2 edges after the owner drops req.
- BUSY -> IDLE on timeout:
  - Fires when MAX_HOLD!=0, the hold counter equals MAX_HOLD, and the owner still requests.
  - After that edge: grant=0, grant_valid=0, last_id=old owner, timeout=1 for exactly one cycle.
  - Grant is high for exactly MAX_HOLD cycles.
  - The timed-out requester is now lowest priority. If it is the only requester, it is re-granted after the one idle cycle.
- Release and timeout on the same edge: release wins and timeout stays 0.
- Invariants:
  - grant is zero or one-hot.
  - grant_valid == |grant.
  - When grant_valid=1, grant == (1 << grant_id).
  - grant_id holds its value while IDLE.
  - timeout is never high when grant_valid=1.
- The hold counter saturates and never wraps. MAX_HOLD=0 means BUSY ends only on release.
- Fairness: with all 8 requesting continuously and each owner releasing after 1 cycle, grant order is 0,1,...,7,0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> grant=0, grant_valid=0, last_id=7, timeout=0. Deassert rst -> after 1 edge, grant=8'h01, grant_id=0.
- Rotation: req=8'hFF, owner drops its bit for 1 cycle after 2 granted cycles, then reasserts -> grant_id sequence 0,1,2,3,4,5,6,7,0. Each grant lasts 2 cycles, separated by 1 idle cycle.
- Wrap-around: last_id=6 after a grant to requester 6; then req=8'b1000_0001 -> grant_id=7. Next round with req=8'b0000_0011 -> grant_id=0.
- Timeout: MAX_HOLD=15, req=8'h04 held constant -> grant=8'h04 for exactly 15 cycles, then grant=0 with timeout=1 for 1 cycle, then re-grant to 2.
- Timeout fairness: MAX_HOLD=4, req=8'h0C constant -> grants 2 (4 cycles), idle with timeout pulse, 3 (4 cycles), idle, 2. No preemption of 2 by 3 mid-hold.
- Mid-operation reset: grant to 5 active with hold counter at 3, assert rst for 1 cycle -> next cycle grant=0, timeout=0, last_id=7. After rst drops with req=8'h21 -> grant_id=0.

Source files
------------

// File: rtl/rr_prio_arbiter8.sv
// Round-robin arbiter for 8 requesters: rotating-priority pick in IDLE, grant held
// in BUSY until the owner releases or the hold limit revokes it.
//   state | meaning
//   IDLE  | no owner; arbitrate among req starting after last_id
//   BUSY  | grant held for grant_id; hold counter running
module rr_prio_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       timeout,
    output logic [2:0] last_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    state_t             state_q, state_d;
    logic [7:0]         grant_q, grant_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic               grant_valid_q, grant_valid_d;
    logic               timeout_q, timeout_d;
    logic [2:0]         last_id_q, last_id_d;
    logic [CNT_W-1:0]   hold_q, hold_d;

    logic               win_found;
    logic [2:0]         win_id;
    logic [2:0]         idx;

    // Search last_id+1 .. last_id+8; the 3-bit add gives the mod-8 wrap for free.
    always_comb begin
        win_found = 1'b0;
        win_id    = 3'd0;
        idx       = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            idx = last_id_q + 3'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        last_id_d     = last_id_q;
        hold_d        = hold_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d       = BUSY;
                    grant_d       = 8'(1) << win_id;
                    grant_id_d    = win_id;
                    grant_valid_d = 1'b1;
                    hold_d        = CNT_W'(1);
                end
            end
            BUSY: begin
                // Release is checked first so it masks a coincident timeout.
                if (!req[grant_id_q]) begin
                    state_d       = IDLE;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                    last_id_d     = grant_id_q;
                    hold_d        = '0;
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LIMIT) begin
                    state_d       = IDLE;
                    grant_d       = 8'h00;
                    grant_valid_d = 1'b0;
                    last_id_d     = grant_id_q;
                    hold_d        = '0;
                    timeout_d     = 1'b1;
                end else if (hold_q != CNT_SAT) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 8'h00;
            grant_id_q    <= 3'd0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            last_id_q     <= 3'd7;
            hold_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            last_id_q     <= last_id_d;
            hold_q        <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;
    assign last_id     = last_id_q;

endmodule

// File: tb/tb_rr_prio_arbiter8.sv
// Directed bench for rr_prio_arbiter8: one instance with the default hold limit
// and one with a hold limit of 4, driven through hand-computed sequences.
module tb_rr_prio_arbiter8;

    logic       clk = 1'b0;
    logic       rst, rst4;
    logic [7:0] req, req4;
    logic [7:0] grant, grant4;
    logic [2:0] grant_id, grant_id4, last_id, last_id4;
    logic       grant_valid, grant_valid4, timeout, timeout4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    rr_prio_arbiter8 #(.MAX_HOLD(15), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_id(grant_id),
        .grant_valid(grant_valid), .timeout(timeout), .last_id(last_id)
    );

    rr_prio_arbiter8 #(.MAX_HOLD(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst4), .req(req4), .grant(grant4), .grant_id(grant_id4),
        .grant_valid(grant_valid4), .timeout(timeout4), .last_id(last_id4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Structural invariants on the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("inv_valid", {7'd0, grant_valid}, {7'd0, |grant});
            chk("inv_onehot", grant & (grant - 8'd1), 8'h00);
            if (grant_valid) begin
                chk("inv_gid", grant, 8'(1) << grant_id);
                chk("inv_to", {7'd0, timeout}, 8'h00);
            end
        end
    end

    initial begin
        rst  = 1'b1;  req  = 8'hFF;
        rst4 = 1'b1;  req4 = 8'h00;

        // Reset with all requesting
        tick(); tick();
        chk("rst_grant", grant, 8'h00);
        chk("rst_valid", {7'd0, grant_valid}, 8'h00);
        chk("rst_last", {5'd0, last_id}, 8'd7);
        chk("rst_to", {7'd0, timeout}, 8'h00);
        rst = 1'b0;
        tick();
        chk("first_grant", grant, 8'h01);
        chk("first_gid", {5'd0, grant_id}, 8'd0);

        // Rotation: 2 granted cycles, drop for 1, reassert
        for (int k = 0; k < 8; k++) begin
            chk("rot_gid", {5'd0, grant_id}, 8'(k));
            chk("rot_grant", grant, 8'(1) << k);
            tick();
            chk("rot_hold", grant, 8'(1) << k);
            req = 8'hFF & ~(8'(1) << k);
            tick();
            chk("rot_idle", grant, 8'h00);
            chk("rot_last", {5'd0, last_id}, 8'(k));
            chk("rot_gid_hold", {5'd0, grant_id}, 8'(k));
            req = 8'hFF;
            tick();
        end
        chk("rot_wrap_gid", {5'd0, grant_id}, 8'd0);

        // Wrap-around
        req = 8'h00; tick();
        chk("idle_none", grant, 8'h00);
        tick();
        chk("idle_stay", {7'd0, grant_valid}, 8'h00);
        req = 8'h40; tick();
        chk("wrap_g6", {5'd0, grant_id}, 8'd6);
        req = 8'h00; tick();
        chk("wrap_last6", {5'd0, last_id}, 8'd6);
        req = 8'h81; tick();
        chk("wrap_g7", {5'd0, grant_id}, 8'd7);
        req = 8'h00; tick();
        chk("wrap_last7", {5'd0, last_id}, 8'd7);
        req = 8'h03; tick();
        chk("wrap_g0", {5'd0, grant_id}, 8'd0);
        req = 8'h00; tick();

        // Timeout with MAX_HOLD=15; a second requester appears mid-hold
        req = 8'h04; tick();
        chk("to_grant", grant, 8'h04);
        for (int i = 1; i < 15; i++) begin
            if (i == 5) req = 8'h0C;
            if (i == 7) req = 8'h04;
            tick();
            chk("to_held", grant, 8'h04);
            chk("to_nopulse", {7'd0, timeout}, 8'h00);
        end
        tick();
        chk("to_revoke", grant, 8'h00);
        chk("to_pulse", {7'd0, timeout}, 8'h01);
        chk("to_last", {5'd0, last_id}, 8'd2);
        tick();
        chk("to_regrant", grant, 8'h04);
        chk("to_pulse_end", {7'd0, timeout}, 8'h00);
        req = 8'h00; tick();

        // Timeout fairness with MAX_HOLD=4
        rst4 = 1'b0; req4 = 8'h0C;
        tick();
        chk("f_g2", {5'd0, grant_id4}, 8'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_hold2", grant4, 8'h04);
        end
        tick();
        chk("f_to1", {7'd0, timeout4}, 8'h01);
        chk("f_idle1", grant4, 8'h00);
        tick();
        chk("f_g3", grant4, 8'h08);
        chk("f_to1_end", {7'd0, timeout4}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_hold3", grant4, 8'h08);
        end
        tick();
        chk("f_to2", {7'd0, timeout4}, 8'h01);
        chk("f_last3", {5'd0, last_id4}, 8'd3);
        tick();
        chk("f_g2b", grant4, 8'h04);

        // Release coincident with hold limit: release wins, no pulse
        tick(); tick(); tick();
        chk("rel_at_lim_held", grant4, 8'h04);
        req4 = 8'h08;
        tick();
        chk("rel_at_lim_grant", grant4, 8'h00);
        chk("rel_at_lim_to", {7'd0, timeout4}, 8'h00);
        chk("rel_at_lim_last", {5'd0, last_id4}, 8'd2);

        // Mid-operation reset on the main instance
        req = 8'h20; tick();
        chk("mr_g5", {5'd0, grant_id}, 8'd5);
        tick(); tick();
        rst = 1'b1; tick();
        chk("mr_grant", grant, 8'h00);
        chk("mr_to", {7'd0, timeout}, 8'h00);
        chk("mr_last", {5'd0, last_id}, 8'd7);
        rst = 1'b0; req = 8'h21; tick();
        chk("mr_g0", {5'd0, grant_id}, 8'd0);
        chk("mr_grant0", grant, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
